dmem_lsu_ctrl: RTL and testbench

- Load/store sequencer between the single-cycle core's memory stage and the word-wide data memory (synchronous read, write-or-read per cycle, no byte enables).
- Converts LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Sub-word stores use a read-modify-write.
- Loads are returned byte/half extracted and sign- or zero-extended.

---
 rtl/dmem_lsu_ctrl_if.sv | 50 +++++
 rtl/dmem_lsu_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_lsu_ctrl_if
// Bundles the three buses around the load/store sequencer:
//   req_*  : request from the core memory stage (valid/ready handshake)
//   rsp_*  : one-cycle completion pulse back to the core (no backpressure)
//   mem_*  : word-wide synchronous data memory port (no byte enables)
// Modports:
//   slave  : the sequencer (dmem_lsu_ctrl)
//   master : the environment around it (core plus data memory)
// Parameters:
//   ADDR_W : word address width of the data memory (byte address is ADDR_W+2)
//   DATA_W : memory word width, only 32 is supported
// ---------------------------------------------------------------------------
interface dmem_lsu_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W+1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/dmem_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_lsu_ctrl
// Load/store sequencer between a single-cycle core's memory stage and a
// word-wide synchronous data memory. Turns LB/LH/LW/LBU/LHU/SB/SH/SW into word
// accesses; sub-word stores are done as read-modify-write, loads come back
// lane-extracted and sign- or zero-extended.
//
// Ports:
//   clk_150_mhz : clock, all state on the rising edge
//   rst         : asynchronous, active-high reset
//   bus         : dmem_lsu_ctrl_if.slave
//                 req_valid/req_ready/req_we/req_size/req_unsigned/
//                 req_addr (byte)/req_wdata  -- request handshake
//                 rsp_valid/rsp_rdata/rsp_err -- completion pulse
//                 mem_addr (word)/mem_wdata/mem_we/mem_rdata -- memory port
//
// Latencies counted in cycles after the accepting edge (rsp_valid visible):
//   load 2, word store 2, sub-word store 3, trapped misaligned access 1.
//
// Optional feature, macro DMEM_MISALIGN_TRAP_EN:
//   defined   -- a half with addr[0]=1 or a word with addr[1:0]!=0 skips the
//                memory and completes next cycle with rsp_err=1.
//   undefined -- rsp_err is always 0 and the low address bits are ignored.
// ---------------------------------------------------------------------------
module dmem_lsu_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic            clk_150_mhz,
    input  logic            rst,
    dmem_lsu_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LD_DATA,
        S_RMW_MERGE,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    state_t            state_q, state_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              mem_we_q, mem_we_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept;
    logic              trap_hit;

    // Ready is also gated by rst so nothing can be accepted while reset is
    // held, even before the state register has been cleared.
    assign bus.req_ready = (state_q == S_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
    // Size 11 is treated as a word, so size[1] alone selects the word check.
    assign trap_hit = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
    assign trap_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state and capture logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d signal gets a default first, so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        we_d      = we_q;
        uns_d     = uns_q;
        wdata_d   = wdata_q;
        rsp_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = bus.req_addr;
                    size_d  = bus.req_size;
                    we_d    = bus.req_we;
                    uns_d   = bus.req_unsigned;
                    wdata_d = bus.req_wdata;
                    if (trap_hit) begin
                        state_d   = S_DONE;
                        rsp_err_d = 1'b1;
                    end else if (!bus.req_we) begin
                        state_d = S_RD;
                    end else if (bus.req_size[1]) begin
                        state_d = S_WR;
                    end else begin
                        // Sub-word store: read the word first, merge later.
                        state_d = S_RD;
                    end
                end
            end
            S_RD:        state_d = we_q ? S_RMW_MERGE : S_LD_DATA;
            S_LD_DATA:   state_d = S_IDLE;
            S_RMW_MERGE: state_d = S_DONE;
            S_WR:        state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        // Output flops are loaded from the state being entered, so they line
        // up exactly with that state and drop asynchronously on reset.
        rsp_valid_d = (state_d == S_LD_DATA) || (state_d == S_DONE);
        mem_we_d    = (state_d == S_RMW_MERGE) || (state_d == S_WR);
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_150_mhz or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            mem_we_q    <= mem_we_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Load lane extraction and extension (used in LD_DATA)
    // -----------------------------------------------------------------------
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;

    always_comb begin
        ld_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_BYTE: ld_ext = uns_q ? {{(DATA_W-8){1'b0}}, ld_byte}
                                    : {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = uns_q ? {{(DATA_W-16){1'b0}}, ld_half}
                                    : {{(DATA_W-16){ld_half[15]}}, ld_half};
            default: ld_ext = bus.mem_rdata;
        endcase
    end

    // -----------------------------------------------------------------------
    // Read-modify-write merge (used in RMW_MERGE, sub-word stores only)
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] rmw_word;

    always_comb begin
        rmw_word = bus.mem_rdata;
        if (size_q == SZ_BYTE) begin
            rmw_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            rmw_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from registered state and captured fields only
    // -----------------------------------------------------------------------
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = (state_q == S_LD_DATA) ? ld_ext : '0;

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q[ADDR_W+1:2];
    assign bus.mem_wdata = (state_q == S_RMW_MERGE) ? rmw_word :
                           (state_q == S_WR)        ? wdata_q  : '0;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_lsu_ctrl
// Bench for dmem_lsu_ctrl: a behavioural word memory on the mem_* port, a
// reference memory image with load/store rules written as shift-and-mask
// arithmetic, a table of hand-derived vectors, hand-written sequences for
// reset abort and misalignment, then randomized traffic.
// Honours DMEM_MISALIGN_TRAP_EN when computing expectations.
// ---------------------------------------------------------------------------
module tb_dmem_lsu_ctrl;
    localparam int ADDR_W = 12;
    localparam int AW     = ADDR_W + 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk_150_mhz = 1'b0;
    logic rst;

    dmem_lsu_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

    dmem_lsu_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk_150_mhz (clk_150_mhz),
        .rst         (rst),
        .bus         (bus)
    );

    initial forever #5 clk_150_mhz = ~clk_150_mhz;

    // Data memory: synchronous read, write-or-read per cycle.
    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    always @(posedge clk_150_mhz) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        else            bus.mem_rdata     <= mem[bus.mem_addr];
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ----------------------------- reference rules -------------------------
    function automatic logic is_trap(input logic [1:0] size, input logic [AW-1:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
        return (size == 2'd1 && a[0]) || (size >= 2'd2 && a[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic uns, input logic [AW-1:0] a);
        logic [31:0] v;
        int sh;
        if (size == 2'd0) begin
            sh = 8 * int'(a[1:0]);
            v  = (w >> sh) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            sh = 16 * int'(a[1]);
            v  = (w >> sh) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [1:0] size,
                                                input logic [31:0] wd, input logic [AW-1:0] a);
        logic [31:0] mask;
        int sh;
        if (size >= 2'd2) return wd;
        sh   = (size == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
        mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    // ----------------------------- transaction driver ----------------------
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [AW-1:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat, output logic err,
                          output int n_we, output int we_cyc,
                          output logic [31:0] w_word, output logic [ADDR_W-1:0] w_addr);
        rdata = 32'h0; lat = -1; err = 1'b0; n_we = 0; we_cyc = -1;
        w_word = 32'h0; w_addr = '0;
        @(negedge clk_150_mhz);
        check("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk_150_mhz);
        #1;
        // Scramble the request fields: the controller must use its captures.
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = AW'($urandom);
        bus.req_wdata    = $urandom;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_150_mhz);
            if (bus.mem_we) begin
                n_we++;
                we_cyc = c;
                w_word = bus.mem_wdata;
                w_addr = bus.mem_addr;
            end
            if (bus.rsp_valid) begin
                lat   = c;
                rdata = bus.rsp_rdata;
                err   = bus.rsp_err;
                break;
            end
        end
    endtask

    // Runs one request and checks it against the reference image.
    task automatic run_checked(input logic we, input logic [1:0] size, input logic uns,
                               input logic [AW-1:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output int lat,
                               output logic err, output logic [31:0] w_word);
        int n_we, we_cyc, e_lat, e_nwe, widx;
        logic [ADDR_W-1:0] w_addr;
        logic [31:0] e_rdata, e_word;
        logic trap;
        widx = int'(addr[AW-1:2]);
        trap = is_trap(size, addr);
        do_req(we, size, uns, addr, wdata, rdata, lat, err, n_we, we_cyc, w_word, w_addr);
        e_word = ref_mem[widx];
        if (trap) begin
            e_lat = 1; e_rdata = 32'h0; e_nwe = 0;
        end else if (!we) begin
            e_lat = 2; e_rdata = ext_load(ref_mem[widx], size, uns, addr); e_nwe = 0;
        end else begin
            e_lat = (size >= 2'd2) ? 2 : 3; e_rdata = 32'h0; e_nwe = 1;
            e_word = merge_store(ref_mem[widx], size, wdata, addr);
        end
        check("latency", lat, e_lat);
        check("rsp_rdata", rdata, e_rdata);
        check("rsp_err", {31'b0, err}, {31'b0, trap});
        check("mem_we_pulses", n_we, e_nwe);
        if (we && !trap) begin
            check("mem_addr_at_we", {20'b0, w_addr}, {20'b0, addr[AW-1:2]});
            check("mem_wdata_at_we", w_word, e_word);
            check("mem_we_cycle", we_cyc, e_lat - 1);
            ref_mem[widx] = e_word;
        end
    endtask

    // ----------------------------- directed table --------------------------
    typedef struct {
        logic            we;
        logic [1:0]      size;
        logic            uns;
        logic [AW-1:0]   addr;
        logic [31:0]     wdata;
        logic [31:0]     exp_rdata;
        logic [31:0]     exp_wword;
        int              exp_lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] rd, ww;
        int lat;
        logic err;
        logic saw_we, saw_rsp;

        vecs[0] = '{1'b0, 2'd0, 1'b0, 14'h14, 32'h0,          32'h0000_0001, 32'h0,          2};
        vecs[1] = '{1'b0, 2'd0, 1'b0, 14'h17, 32'h0,          32'hFFFF_FF80, 32'h0,          2};
        vecs[2] = '{1'b0, 2'd0, 1'b1, 14'h17, 32'h0,          32'h0000_0080, 32'h0,          2};
        vecs[3] = '{1'b0, 2'd1, 1'b0, 14'h16, 32'h0,          32'hFFFF_80FF, 32'h0,          2};
        vecs[4] = '{1'b0, 2'd1, 1'b1, 14'h16, 32'h0,          32'h0000_80FF, 32'h0,          2};
        vecs[5] = '{1'b1, 2'd0, 1'b0, 14'h15, 32'hAAAA_AA5A,  32'h0,         32'h80FF_5A01,  3};
        vecs[6] = '{1'b0, 2'd2, 1'b0, 14'h14, 32'h0,          32'h80FF_5A01, 32'h0,          2};
        vecs[7] = '{1'b1, 2'd2, 1'b0, 14'h20, 32'hDEAD_BEEF,  32'h0,         32'hDEAD_BEEF,  2};
        vecs[8] = '{1'b1, 2'd1, 1'b0, 14'h22, 32'hFFFF_1234,  32'h0,         32'h1234_BEEF,  3};
        vecs[9] = '{1'b0, 2'd2, 1'b0, 14'h20, 32'h0,          32'h1234_BEEF, 32'h0,          2};

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[5]     = 32'h80FF_7F01;
        ref_mem[5] = 32'h80FF_7F01;

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = 32'h0;

        // Reset: hold 3 cycles, all outputs 0 meanwhile.
        rst = 1'b1;
        repeat (2) @(posedge clk_150_mhz);
        @(negedge clk_150_mhz);
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", {20'b0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        @(posedge clk_150_mhz);
        @(negedge clk_150_mhz);
        rst = 1'b0;
        @(negedge clk_150_mhz);
        check("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);

        // Directed vectors: model checks plus the hand-derived values.
        for (int i = 0; i < 10; i++) begin
            run_checked(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                        rd, lat, err, ww);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].we) check($sformatf("vec%0d_wword", i), ww, vecs[i].exp_wword);
        end

        // Reset in the RD cycle of SH 0x22: aborted, word 8 untouched.
        @(negedge clk_150_mhz);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'd1;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 14'h22;
        bus.req_wdata    = 32'h0000_5678;
        @(posedge clk_150_mhz);
        #1 bus.req_valid = 1'b0;
        saw_we  = 1'b0;
        saw_rsp = 1'b0;
        @(negedge clk_150_mhz);
        saw_we  = saw_we | bus.mem_we;
        saw_rsp = saw_rsp | bus.rsp_valid;
        rst = 1'b1;
        #1;
        saw_we  = saw_we | bus.mem_we;
        saw_rsp = saw_rsp | bus.rsp_valid;
        repeat (2) begin
            @(negedge clk_150_mhz);
            saw_we  = saw_we | bus.mem_we;
            saw_rsp = saw_rsp | bus.rsp_valid;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk_150_mhz);
            saw_we  = saw_we | bus.mem_we;
            saw_rsp = saw_rsp | bus.rsp_valid;
        end
        check("abort_no_mem_we", {31'b0, saw_we}, 32'd0);
        check("abort_no_rsp", {31'b0, saw_rsp}, 32'd0);
        check("abort_word8_kept", mem[8], 32'h1234_BEEF);
        run_checked(1'b0, 2'd2, 1'b0, 14'h20, 32'h0, rd, lat, err, ww);
        check("after_abort_lw", rd, 32'h1234_BEEF);

        // Misaligned word load.
        run_checked(1'b0, 2'd2, 1'b0, 14'h21, 32'h0, rd, lat, err, ww);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("misalign_lat", lat, 32'd1);
        check("misalign_err", {31'b0, err}, 32'd1);
`else
        check("misalign_lat", lat, 32'd2);
        check("misalign_rdata", rd, 32'h1234_BEEF);
`endif

        // Randomized traffic in a small window so accesses overlap.
        for (int i = 0; i < 200; i++) begin
            run_checked(1'($urandom), 2'($urandom), 1'($urandom),
                        AW'($urandom_range(0, 63)), $urandom, rd, lat, err, ww);
        end

        for (int i = 0; i < 16; i++) begin
            check($sformatf("final_word%0d", i), mem[i], ref_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
